// File: rtl/uart_dbus_bridge_pkg.sv
// Shared definitions for the UART debug bus bridge: frame command codes,
// response codes, FSM state encoding and a byte-lane helper.
package uart_dbus_bridge_pkg;

  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_CSUM,
    ST_BUS,
    ST_RESP
  } state_t;

  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_dbus_bridge_if.sv
// 32-bit data-bus initiator port: the bridge drives the master modport,
// the arbiter/slave side uses the slave modport.
interface uart_dbus_bridge_if;
  logic [31:0] master_address;
  logic [3:0]  master_byteenable;
  logic        master_read;
  logic        master_write;
  logic [31:0] master_wrdata;
  logic [31:0] master_rddata;
  logic        master_stall;

  modport master (
    output master_address, master_byteenable, master_read, master_write, master_wrdata,
    input  master_rddata, master_stall
  );

  modport slave (
    input  master_address, master_byteenable, master_read, master_write, master_wrdata,
    output master_rddata, master_stall
  );
endinterface

// File: rtl/uart_dbus_bridge.sv
// UART byte-stream to 32-bit bus master bridge (read/write frames, UART response).
// Optional frame checksum enabled by defining UART_DBUS_BRIDGE_CHECKSUM_EN.
module uart_dbus_bridge
  import uart_dbus_bridge_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  uart_dbus_bridge_if.master         bus,
  output logic                       busy
);

`ifdef UART_DBUS_BRIDGE_CHECKSUM_EN
  localparam state_t FRAME_END = ST_CSUM;
`else
  localparam state_t FRAME_END = ST_BUS;
`endif

  state_t      state_reg, state_next;
  logic [1:0]  byte_cnt_reg, byte_cnt_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] data_reg, data_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        is_write_reg, is_write_next;
  logic        nak_reg, nak_next;
  logic [1:0]  resp_idx_reg, resp_idx_next;
  logic [23:0] tmo_cnt_reg, tmo_cnt_next;
  logic        tx_start_d_reg;
`ifdef UART_DBUS_BRIDGE_CHECKSUM_EN
  logic [7:0]  csum_reg, csum_next;
`endif

  logic        req_read, req_write, tx_start_c;
  logic [7:0]  tx_data_c;
  logic        frame_state, tmo_hit;
  logic [1:0]  resp_last;

  assign frame_state = (state_reg == ST_ADDR) || (state_reg == ST_DATA) || (state_reg == ST_CSUM);
  assign tmo_hit     = (tmo_cnt_reg == TIMEOUT_CYCLES - 24'd1);
  // NAK and write ACK are single bytes; read data is four.
  assign resp_last   = (nak_reg || is_write_reg) ? 2'd0 : 2'd3;

  always_comb begin
    state_next    = state_reg;
    byte_cnt_next = byte_cnt_reg;
    addr_next     = addr_reg;
    data_next     = data_reg;
    rdata_next    = rdata_reg;
    is_write_next = is_write_reg;
    nak_next      = nak_reg;
    resp_idx_next = resp_idx_reg;
    tmo_cnt_next  = '0;
`ifdef UART_DBUS_BRIDGE_CHECKSUM_EN
    csum_next     = csum_reg;
`endif
    req_read      = 1'b0;
    req_write     = 1'b0;
    tx_start_c    = 1'b0;
    tx_data_c     = 8'h00;

    // Inter-byte timeout only while a frame is being collected.
    if (frame_state && !rx_valid) begin
      if (tmo_hit) state_next = ST_IDLE;
      else         tmo_cnt_next = tmo_cnt_reg + 24'd1;
    end

    case (state_reg)
      ST_IDLE: begin
        if (rx_valid && (rx_data == CMD_READ || rx_data == CMD_WRITE)) begin
          is_write_next = (rx_data == CMD_WRITE);
          nak_next      = 1'b0;
          byte_cnt_next = 2'd0;
          state_next    = ST_ADDR;
`ifdef UART_DBUS_BRIDGE_CHECKSUM_EN
          csum_next     = rx_data;
`endif
        end
      end
      ST_ADDR: begin
        if (rx_valid) begin
          addr_next     = {rx_data, addr_reg[31:8]};
          byte_cnt_next = byte_cnt_reg + 2'd1;
`ifdef UART_DBUS_BRIDGE_CHECKSUM_EN
          csum_next     = csum_reg ^ rx_data;
`endif
          if (byte_cnt_reg == 2'd3) state_next = is_write_reg ? ST_DATA : FRAME_END;
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          data_next     = {rx_data, data_reg[31:8]};
          byte_cnt_next = byte_cnt_reg + 2'd1;
`ifdef UART_DBUS_BRIDGE_CHECKSUM_EN
          csum_next     = csum_reg ^ rx_data;
`endif
          if (byte_cnt_reg == 2'd3) state_next = FRAME_END;
        end
      end
`ifdef UART_DBUS_BRIDGE_CHECKSUM_EN
      ST_CSUM: begin
        if (rx_valid) begin
          resp_idx_next = 2'd0;
          if (rx_data == csum_reg) begin
            state_next = ST_BUS;
          end else begin
            nak_next   = 1'b1;
            state_next = ST_RESP;
          end
        end
      end
`endif
      ST_BUS: begin
        req_read  = !is_write_reg;
        req_write = is_write_reg;
        if (!bus.master_stall) begin
          if (!is_write_reg) rdata_next = bus.master_rddata;
          resp_idx_next = 2'd0;
          state_next    = ST_RESP;
        end
      end
      ST_RESP: begin
        tx_data_c = nak_reg ? NAK_BYTE : (is_write_reg ? ACK_BYTE : byte_of(rdata_reg, resp_idx_reg));
        // The transmitter only raises busy a cycle after tx_start, so skip that cycle too.
        if (!tx_busy && !tx_start_d_reg) begin
          tx_start_c = 1'b1;
          if (resp_idx_reg == resp_last) begin
            resp_idx_next = 2'd0;
            state_next    = ST_IDLE;
          end else begin
            resp_idx_next = resp_idx_reg + 2'd1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      byte_cnt_reg   <= '0;
      addr_reg       <= '0;
      data_reg       <= '0;
      rdata_reg      <= '0;
      is_write_reg   <= 1'b0;
      nak_reg        <= 1'b0;
      resp_idx_reg   <= '0;
      tmo_cnt_reg    <= '0;
      tx_start_d_reg <= 1'b0;
`ifdef UART_DBUS_BRIDGE_CHECKSUM_EN
      csum_reg       <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      byte_cnt_reg   <= byte_cnt_next;
      addr_reg       <= addr_next;
      data_reg       <= data_next;
      rdata_reg      <= rdata_next;
      is_write_reg   <= is_write_next;
      nak_reg        <= nak_next;
      resp_idx_reg   <= resp_idx_next;
      tmo_cnt_reg    <= tmo_cnt_next;
      tx_start_d_reg <= tx_start_c;
`ifdef UART_DBUS_BRIDGE_CHECKSUM_EN
      csum_reg       <= csum_next;
`endif
    end
  end

  assign bus.master_address    = addr_reg & 32'hFFFF_FFFC;
  assign bus.master_byteenable = (req_read || req_write) ? 4'b1111 : 4'b0000;
  assign bus.master_read       = req_read;
  assign bus.master_write      = req_write;
  assign bus.master_wrdata     = data_reg;
  assign tx_data               = tx_data_c;
  assign tx_start              = tx_start_c;
  assign busy                  = (state_reg != ST_IDLE);

endmodule
